// File: rtl/mux2_sel_if.sv
// Signal bundle for the mux2_sel selector: data/select inputs, combinational and
// registered results, and the select-toggle debug counter.
interface mux2_sel_if #(
  parameter int unsigned NBITS    = 1,
  parameter int unsigned CNT_BITS = 8
);
  logic [NBITS-1:0]    in0;
  logic [NBITS-1:0]    in1;
  logic                sel;
  logic [NBITS-1:0]    out;
  logic [NBITS-1:0]    out_reg;
  logic [CNT_BITS-1:0] sel_toggles;

  modport master (
    output in0, in1, sel,
    input  out, out_reg, sel_toggles
  );

  modport slave (
    input  in0, in1, sel,
    output out, out_reg, sel_toggles
  );
endinterface

// File: rtl/mux2_sel.sv
// 2:1 selector with a zero-latency combinational result, a registered copy of it,
// and a saturating counter of select changes for debug visibility.
module mux2_sel #(
  parameter int unsigned NBITS    = 1,
  parameter int unsigned CNT_BITS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  mux2_sel_if.slave  bus
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [NBITS-1:0]    mux_c;
  logic [NBITS-1:0]    out_reg_d, out_reg_q;
  logic                sel_prev_d, sel_prev_q;
  logic [CNT_BITS-1:0] cnt_d, cnt_q;

  // Ternary keeps X on bits where the inputs differ and sel is unknown.
  assign mux_c = bus.sel ? bus.in1 : bus.in0;

  always_comb begin
    out_reg_d  = mux_c;
    sel_prev_d = bus.sel;
    cnt_d      = cnt_q;
    if ((bus.sel != sel_prev_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg_q  <= '0;
      sel_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_reg_q  <= out_reg_d;
      sel_prev_q <= sel_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out         = mux_c;
  assign bus.out_reg     = out_reg_q;
  assign bus.sel_toggles = cnt_q;

endmodule

// File: tb/tb_mux2_sel.sv
// Directed self-checking bench for mux2_sel: default, narrow-counter and wide-data instances.
module tb_mux2_sel;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  mux2_sel_if #(.NBITS(1), .CNT_BITS(8)) if_a ();
  mux2_sel_if #(.NBITS(1), .CNT_BITS(2)) if_s ();
  mux2_sel_if #(.NBITS(8), .CNT_BITS(8)) if_w ();

  mux2_sel #(.NBITS(1), .CNT_BITS(8)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  mux2_sel #(.NBITS(1), .CNT_BITS(2)) u_dut_s (.clk(clk), .reset_n(reset_n), .bus(if_s.slave));
  mux2_sel #(.NBITS(8), .CNT_BITS(8)) u_dut_w (.clk(clk), .reset_n(reset_n), .bus(if_w.slave));

  // One rising edge; returns 1 time unit after it with clk still high.
  task automatic tick();
    clk = 1'b0;
    #4;
    clk = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    n_tests++; if (if_a.out_reg !== 1'b0) begin $display("FAIL reset_out_reg: got %0h expected 0", if_a.out_reg); n_fail++; end
    n_tests++; if (if_a.sel_toggles !== 8'd0) begin $display("FAIL reset_toggles: got %0d expected 0", if_a.sel_toggles); n_fail++; end
    n_tests++; if (if_s.sel_toggles !== 2'd0) begin $display("FAIL reset_sat_toggles: got %0d expected 0", if_s.sel_toggles); n_fail++; end
    n_tests++; if (if_w.out_reg !== 8'h00) begin $display("FAIL reset_wide_out_reg: got %0h expected 00", if_w.out_reg); n_fail++; end
  endtask

  task automatic test_comb_in_reset();
    if_a.in0 = 1'b1; if_a.in1 = 1'b0; if_a.sel = 1'b0;
    #1;
    n_tests++; if (if_a.out !== 1'b1) begin $display("FAIL rst_comb_sel0: got %0h expected 1", if_a.out); n_fail++; end
    n_tests++; if (if_a.out_reg !== 1'b0) begin $display("FAIL rst_hold_out_reg0: got %0h expected 0", if_a.out_reg); n_fail++; end
    n_tests++; if (if_a.sel_toggles !== 8'd0) begin $display("FAIL rst_hold_toggles0: got %0d expected 0", if_a.sel_toggles); n_fail++; end
    if_a.sel = 1'b1;
    #1;
    n_tests++; if (if_a.out !== 1'b0) begin $display("FAIL rst_comb_sel1: got %0h expected 0", if_a.out); n_fail++; end
    n_tests++; if (if_a.out_reg !== 1'b0) begin $display("FAIL rst_hold_out_reg1: got %0h expected 0", if_a.out_reg); n_fail++; end
    n_tests++; if (if_a.sel_toggles !== 8'd0) begin $display("FAIL rst_hold_toggles1: got %0d expected 0", if_a.sel_toggles); n_fail++; end
  endtask

  task automatic test_comb_truth();
    // {in0, in1, sel, expected_out}
    logic [3:0] tt [8];
    tt = '{4'b0000, 4'b0100, 4'b1001, 4'b1101, 4'b0010, 4'b0111, 4'b1010, 4'b1111};
    for (int i = 0; i < 8; i++) begin
      if_a.in0 = tt[i][3];
      if_a.in1 = tt[i][2];
      if_a.sel = tt[i][1];
      #1;
      n_tests++;
      if (if_a.out !== tt[i][0]) begin
        $display("FAIL truth_%0b%0b%0b: got %0h expected %0h", tt[i][3], tt[i][2], tt[i][1], if_a.out, tt[i][0]);
        n_fail++;
      end
    end
  endtask

  task automatic test_registered();
    if_a.in0 = 1'b0; if_a.in1 = 1'b1; if_a.sel = 1'b1;
    #1;
    reset_n = 1'b1;
    tick();
    n_tests++; if (if_a.out_reg !== 1'b1) begin $display("FAIL reg_first_edge: got %0h expected 1", if_a.out_reg); n_fail++; end
    n_tests++; if (if_a.sel_toggles !== 8'd1) begin $display("FAIL reg_first_toggle: got %0d expected 1", if_a.sel_toggles); n_fail++; end
    if_a.sel = 1'b0;
    #1;
    n_tests++; if (if_a.out !== 1'b0) begin $display("FAIL reg_comb_now: got %0h expected 0", if_a.out); n_fail++; end
    n_tests++; if (if_a.out_reg !== 1'b1) begin $display("FAIL reg_held: got %0h expected 1", if_a.out_reg); n_fail++; end
    tick();
    n_tests++; if (if_a.out_reg !== 1'b0) begin $display("FAIL reg_next_edge: got %0h expected 0", if_a.out_reg); n_fail++; end
    n_tests++; if (if_a.sel_toggles !== 8'd2) begin $display("FAIL reg_second_toggle: got %0d expected 2", if_a.sel_toggles); n_fail++; end
  endtask

  task automatic test_toggle_count();
    logic [4:0] seq;
    seq = 5'b11010;  // applied LSB first: 0,1,0,1,1
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    if_a.in0 = 1'b0; if_a.in1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if_a.sel = seq[i];
      tick();
    end
    n_tests++; if (if_a.sel_toggles !== 8'd3) begin $display("FAIL toggle_count: got %0d expected 3", if_a.sel_toggles); n_fail++; end
    n_tests++; if (if_a.out_reg !== 1'b1) begin $display("FAIL toggle_out_reg: got %0h expected 1", if_a.out_reg); n_fail++; end
    reset_n = 1'b0;
    #1;
    n_tests++; if (if_a.sel_toggles !== 8'd0) begin $display("FAIL async_rst_toggles: got %0d expected 0", if_a.sel_toggles); n_fail++; end
    n_tests++; if (if_a.out_reg !== 1'b0) begin $display("FAIL async_rst_out_reg: got %0h expected 0", if_a.out_reg); n_fail++; end
    n_tests++; if (if_a.out !== 1'b1) begin $display("FAIL async_rst_out: got %0h expected 1", if_a.out); n_fail++; end
    reset_n = 1'b1;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [7];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    if_s.in0 = 1'b0; if_s.in1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      // Six alternating edges starting at 1, then a seventh that repeats 0.
      if_s.sel = (i < 6) ? ((i % 2) == 0) : 1'b0;
      tick();
      n_tests++;
      if (if_s.sel_toggles !== exp_cnt[i]) begin
        $display("FAIL sat_edge%0d: got %0d expected %0d", i, if_s.sel_toggles, exp_cnt[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_wide();
    if_w.in0 = 8'hA5; if_w.in1 = 8'h3C; if_w.sel = 1'b0;
    #1;
    n_tests++; if (if_w.out !== 8'hA5) begin $display("FAIL wide_sel0: got %0h expected a5", if_w.out); n_fail++; end
    if_w.sel = 1'b1;
    #1;
    n_tests++; if (if_w.out !== 8'h3C) begin $display("FAIL wide_sel1: got %0h expected 3c", if_w.out); n_fail++; end
    tick();
    n_tests++; if (if_w.out_reg !== 8'h3C) begin $display("FAIL wide_reg1: got %0h expected 3c", if_w.out_reg); n_fail++; end
    if_w.sel = 1'b0;
    #1;
    n_tests++; if (if_w.out_reg !== 8'h3C) begin $display("FAIL wide_reg_held: got %0h expected 3c", if_w.out_reg); n_fail++; end
    tick();
    n_tests++; if (if_w.out_reg !== 8'hA5) begin $display("FAIL wide_reg0: got %0h expected a5", if_w.out_reg); n_fail++; end
  endtask

  task automatic test_back_to_back();
    // {in0, in1, sel, expected_out_reg}
    logic [3:0] vec [4];
    vec = '{4'b1001, 4'b1010, 4'b0111, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      if_a.in0 = vec[i][3];
      if_a.in1 = vec[i][2];
      if_a.sel = vec[i][1];
      tick();
      n_tests++;
      if (if_a.out_reg !== vec[i][0]) begin
        $display("FAIL b2b_cycle%0d: got %0h expected %0h", i, if_a.out_reg, vec[i][0]);
        n_fail++;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    reset_n = 1'b0;
    if_a.in0 = '0; if_a.in1 = '0; if_a.sel = 1'b0;
    if_s.in0 = '0; if_s.in1 = '0; if_s.sel = 1'b0;
    if_w.in0 = '0; if_w.in1 = '0; if_w.sel = 1'b0;
    #2;
    test_reset();
    test_comb_in_reset();
    test_comb_truth();
    test_registered();
    test_toggle_count();
    test_saturation();
    test_wide();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_sel.md
Name: mux2_sel

Overview:
- Two-input, one-output selector datapath primitive: out = in0 when sel=0, in1 when sel=1.
- The combinational output is the primary function and is independent of clock and reset.
- Also provides a registered copy of the output and a saturating select-toggle counter for downstream pipelining and debug observability.
- Used wherever a 2:1 steering choice is needed in control or datapath logic.

Parameters:
- NBITS, 1, data width of in0, in1, out, out_reg.
- CNT_BITS, 8, width of the select-toggle counter.

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- reset_n  input  1  asynchronous, active-low reset; clears registered state only.
- in0  input  NBITS  data input selected when sel=0.
- in1  input  NBITS  data input selected when sel=1.
- sel  input  1  select: 0 chooses in0, 1 chooses in1.
- out  output  NBITS  combinational mux result.
- out_reg  output  NBITS  out registered on rising clk.
- sel_toggles  output  CNT_BITS  count of clock edges where sel differed from its previous sampled value; saturating.

Behaviour:
- out = sel ? in1 : in0.
  - Purely combinational; zero clock latency.
  - Must settle within the same delta/time step as an input change.
  - Bench samples 1 time unit after applying inputs.
- Clock and reset have no effect on out.
  - out is valid during reset and with clk stopped.
- 1-bit truth table (in0,in1,sel -> out): 000->0, 010->0, 100->1, 110->1, 001->0, 011->1, 101->0, 111->1.
- Per-bit selection for NBITS>1: all bits use the same sel.
- No X propagation masking:
  - sel=X yields X on any bit where in0 and in1 differ.
  - Otherwise the common value is output.
- out_reg:
  - On rising clk, out_reg <= (sel ? in1 : in0); one-cycle latency.
  - Reset value 0.
- Toggle counter:
  - Internal sel_prev register samples sel each rising clk; reset value 0.
  - On each rising clk where sel != sel_prev, sel_toggles increments by 1.
  - At all-ones, sel_toggles holds (saturates); it never wraps.
  - Reset value of sel_toggles is 0.
- Reset:
  - reset_n low asynchronously forces out_reg=0, sel_prev=0, sel_toggles=0 immediately, without waiting for clk.
  - Registers hold those values while reset_n is low.
  - Release is synchronous-safe: the first rising edge with reset_n high updates normally.
  - If sel=1 on that first edge, it counts as a toggle (sel_prev was 0).
- Reset asserted mid-operation discards count and registered data; out is unaffected.
- No handshake, no backpressure, no state machine beyond the registers above.

Test Plan:
- Exhaustive 1-bit combinational: apply all 8 (in0,in1,sel) combos, wait 1 time unit each, check out against the truth table. Specifically (0,1,1)->1, (1,0,0)->1, (1,0,1)->0.
- Combinational during reset: hold reset_n=0, clk stopped; set in0=1, in1=0, sel=0 -> out=1; set sel=1 -> out=0. Check out_reg=0 and sel_toggles=0 throughout.
- Registered path: release reset; in0=0, in1=1, sel=1, one rising edge -> out_reg=1. Then sel=0 -> out=0 immediately, while out_reg stays 1 until the next edge, then 0.
- Toggle count: after reset, drive sel 0,1,0,1,1 on successive edges -> sel_toggles=3. Assert reset_n=0 asynchronously between edges -> sel_toggles=0 and out_reg=0 immediately.
- Saturation: with CNT_BITS=2, alternate sel for 6 edges -> sel_toggles stops at 3 and stays 3.
- Wide data: NBITS=8, in0=8'hA5, in1=8'h3C; sel=0 -> out=8'hA5; sel=1 -> out=8'h3C.
